// File: rtl/ca_run_sequencer.sv
// Run sequencer for a ca3 cellular-automaton array: seeds the array, snapshots
// a number of consecutive generations into a row buffer, then streams them out bytewise.
module ca_run_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [7:0]       rule_in,
  input  logic             left_in,
  input  logic             right_in,
  input  logic [CW-1:0]    n_gens,
  output logic [WIDTH-1:0] ca_state,
  output logic             ca_set_state,
  output logic [7:0]       ca_rule,
  output logic             ca_left,
  output logic             ca_right,
  input  logic [WIDTH-1:0] ca_out,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic             done
);

  localparam int BPR = WIDTH / 8;
  localparam int CLW = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CAPTURE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] row_buf_r [DEPTH];

  logic [WIDTH-1:0] ca_state_r, ca_state_s;
  logic [7:0]       ca_rule_r, ca_rule_s;
  logic             ca_left_r, ca_left_s;
  logic             ca_right_r, ca_right_s;
  logic             ca_set_state_r, ca_set_state_s;
  logic [CW-1:0]    n_gens_r, n_gens_s;
  logic [CW-1:0]    cap_r, cap_s;
  logic [CW-1:0]    row_r, row_s;
  logic [CLW-1:0]   col_r, col_s;
  logic [7:0]       m_data_r, m_data_s;
  logic             m_valid_r, m_valid_s;
  logic             m_last_r, m_last_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  logic [CW-1:0]    n_clamp_s;
  logic             cap_last_s;
  logic             col_last_s;
  logic [CLW-1:0]   ncol_s;
  logic [CW-1:0]    nrow_s;
  logic [WIDTH-1:0] rd_word_s;
  logic [7:0]       first_byte_s;

  // Byte lane select, lane 0 is bits [7:0].
  function automatic logic [7:0] byte_of(input logic [WIDTH-1:0] word,
                                         input logic [CLW-1:0]   col);
    byte_of = word[{col, 3'b000} +: 8];
  endfunction

  assign n_clamp_s  = (n_gens > CW'(DEPTH)) ? CW'(DEPTH) : n_gens;
  assign cap_last_s = ((cap_r + CW'(1)) == n_gens_r);
  assign col_last_s = (col_r == CLW'(BPR - 1));
  assign ncol_s     = col_last_s ? {CLW{1'b0}} : (col_r + CLW'(1));
  assign nrow_s     = col_last_s ? (row_r + CW'(1)) : row_r;
  assign rd_word_s  = row_buf_r[nrow_s[AW-1:0]];
  // Row 0 may be written on the very edge that presents its first byte.
  assign first_byte_s = (cap_r == {CW{1'b0}}) ? ca_out[7:0] : row_buf_r[0][7:0];

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= S_IDLE;
      ca_state_r     <= {WIDTH{1'b0}};
      ca_rule_r      <= 8'd0;
      ca_left_r      <= 1'b0;
      ca_right_r     <= 1'b0;
      ca_set_state_r <= 1'b0;
      n_gens_r       <= {CW{1'b0}};
      cap_r          <= {CW{1'b0}};
      row_r          <= {CW{1'b0}};
      col_r          <= {CLW{1'b0}};
      m_data_r       <= 8'd0;
      m_valid_r      <= 1'b0;
      m_last_r       <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      ca_state_r     <= ca_state_s;
      ca_rule_r      <= ca_rule_s;
      ca_left_r      <= ca_left_s;
      ca_right_r     <= ca_right_s;
      ca_set_state_r <= ca_set_state_s;
      n_gens_r       <= n_gens_s;
      cap_r          <= cap_s;
      row_r          <= row_s;
      col_r          <= col_s;
      m_data_r       <= m_data_s;
      m_valid_r      <= m_valid_s;
      m_last_r       <= m_last_s;
      busy_r         <= busy_s;
      done_r         <= done_s;
    end
  end

  // Generation snapshot buffer; contents are don't-care outside a run.
  always_ff @(posedge clk) begin
    if (state_r == S_CAPTURE) begin
      row_buf_r[cap_r[AW-1:0]] <= ca_out;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_LOAD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (n_gens_r == {CW{1'b0}}) begin
          state_s = S_DONE;
        end else begin
          state_s = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (cap_last_s) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_CAPTURE;
        end
      end
      S_DRAIN: begin
        if (m_valid_r && m_ready && m_last_r) begin
          state_s = S_DONE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and counters.
  always_comb begin
    ca_state_s     = ca_state_r;
    ca_rule_s      = ca_rule_r;
    ca_left_s      = ca_left_r;
    ca_right_s     = ca_right_r;
    n_gens_s       = n_gens_r;
    cap_s          = cap_r;
    row_s          = row_r;
    col_s          = col_r;
    m_data_s       = m_data_r;
    m_valid_s      = m_valid_r;
    m_last_s       = m_last_r;
    ca_set_state_s = 1'b0;
    done_s         = 1'b0;
    busy_s         = (state_s != S_IDLE);
    case (state_r)
      S_IDLE: begin
        if (start) begin
          ca_state_s     = seed;
          ca_rule_s      = rule_in;
          ca_left_s      = left_in;
          ca_right_s     = right_in;
          n_gens_s       = n_clamp_s;
          ca_set_state_s = 1'b1;
          cap_s          = {CW{1'b0}};
          row_s          = {CW{1'b0}};
          col_s          = {CLW{1'b0}};
          m_data_s       = 8'd0;
          m_valid_s      = 1'b0;
          m_last_s       = 1'b0;
        end else begin
          m_valid_s      = 1'b0;
          m_last_s       = 1'b0;
        end
      end
      S_LOAD: begin
        if (n_gens_r == {CW{1'b0}}) begin
          done_s = 1'b1;
        end else begin
          cap_s  = {CW{1'b0}};
        end
      end
      S_CAPTURE: begin
        cap_s = cap_r + CW'(1);
        if (cap_last_s) begin
          m_valid_s = 1'b1;
          row_s     = {CW{1'b0}};
          col_s     = {CLW{1'b0}};
          m_data_s  = first_byte_s;
          m_last_s  = (n_gens_r == CW'(1)) && (BPR == 1);
        end else begin
          m_valid_s = 1'b0;
        end
      end
      S_DRAIN: begin
        if (m_valid_r && m_ready) begin
          if (m_last_r) begin
            m_valid_s = 1'b0;
            m_last_s  = 1'b0;
            done_s    = 1'b1;
          end else begin
            row_s    = nrow_s;
            col_s    = ncol_s;
            m_data_s = byte_of(rd_word_s, ncol_s);
            m_last_s = ((nrow_s + CW'(1)) == n_gens_r) && (ncol_s == CLW'(BPR - 1));
          end
        end else begin
          m_valid_s = m_valid_r;
        end
      end
      S_DONE: begin
        m_valid_s = 1'b0;
        m_last_s  = 1'b0;
      end
      default: begin
        m_valid_s = 1'b0;
        m_last_s  = 1'b0;
      end
    endcase
  end

  assign ca_state     = ca_state_r;
  assign ca_set_state = ca_set_state_r;
  assign ca_rule      = ca_rule_r;
  assign ca_left      = ca_left_r;
  assign ca_right     = ca_right_r;
  assign m_data       = m_data_r;
  assign m_valid      = m_valid_r;
  assign m_last       = m_last_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_ca_run_sequencer.sv
// Bench for ca_run_sequencer with a behavioural ca3 array; expected streams come
// from evolving the seed under the Wolfram rule and serialising rows LSB byte first.
module tb_ca_run_sequencer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] seed;
  logic [7:0]       rule_in;
  logic             left_in;
  logic             right_in;
  logic [CW-1:0]    n_gens;
  logic [WIDTH-1:0] ca_state;
  logic             ca_set_state;
  logic [7:0]       ca_rule;
  logic             ca_left;
  logic             ca_right;
  logic [WIDTH-1:0] ca_out;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  ca_run_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .rule_in(rule_in),
    .left_in(left_in), .right_in(right_in), .n_gens(n_gens),
    .ca_state(ca_state), .ca_set_state(ca_set_state), .ca_rule(ca_rule),
    .ca_left(ca_left), .ca_right(ca_right), .ca_out(ca_out),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One elementary-CA generation; cell WIDTH-1 sees the left boundary.
  function automatic logic [WIDTH-1:0] ca_step(input logic [WIDTH-1:0] g,
      input logic [7:0] ru, input logic l, input logic r);
    logic [WIDTH-1:0] nx;
    logic lv, rv;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) lv = l; else lv = g[i+1];
      if (i == 0) rv = r; else rv = g[i-1];
      nx[i] = ru[{lv, g[i], rv}];
    end
    return nx;
  endfunction

  // Stand-in for ca3: registered row, loaded by set_state.
  always @(posedge clk) begin
    if (ca_set_state) ca_out <= ca_state;
    else              ca_out <= ca_step(ca_out, ca_rule, ca_left, ca_right);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_case(input logic [31:0] s, input logic [7:0] ru, input logic l,
      input logic r, input logic [4:0] n, input int rmode, input int inject,
      input int exp_bytes);
    logic [7:0]  exp_q[$];
    logic [31:0] g;
    int n_eff, idx, cyc, first_v, done_c, last_acc, injected;
    logic prev_stall, prev_l, acc;
    logic [7:0] prev_d;
    n_eff = (n > 5'd16) ? 16 : int'(n);
    g = s;
    for (int k = 0; k < n_eff; k++) begin
      for (int b = 0; b < WIDTH / 8; b++) exp_q.push_back(g[8*b +: 8]);
      g = ca_step(g, ru, l, r);
    end
    @(negedge clk);
    seed = s; rule_in = ru; left_in = l; right_in = r; n_gens = n; start = 1'b1;
    m_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    cyc = 1; idx = 0; first_v = -1; done_c = -1; last_acc = -1; injected = 0;
    prev_stall = 1'b0; prev_d = 8'd0; prev_l = 1'b0;
    while (cyc < 400 && done_c < 0) begin
      if (cyc == 1) begin
        check("load_set_state", ca_set_state, 1);
        check("load_ca_state", ca_state, s);
      end
      if (cyc == 2) check("set_state_clear", ca_set_state, 0);
      if (done) begin
        done_c = cyc;
        check("done_valid_low", m_valid, 0);
        check("done_busy", busy, 1);
      end else begin
        if (m_valid) begin
          if (first_v < 0) first_v = cyc;
          if (prev_stall) begin
            check("stall_data", m_data, prev_d);
            check("stall_last", m_last, prev_l);
          end
        end
        if (inject != 0 && first_v >= 0 && injected == 0) begin
          seed = 32'd0; start = 1'b1; injected = 1;
        end else begin
          start = 1'b0;
        end
        m_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        acc = m_valid && m_ready;
        if (acc) begin
          if (idx < exp_q.size()) check("byte", m_data, exp_q[idx]);
          else check("extra_byte", idx, exp_q.size());
          check("last_flag", m_last, (idx == exp_bytes - 1));
          last_acc = cyc;
          idx++;
        end
        prev_stall = m_valid && !m_ready;
        prev_d = m_data;
        prev_l = m_last;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check("done_seen", (done_c >= 0), 1);
    check("byte_count", idx, exp_bytes);
    if (n_eff == 0) begin
      check("done_latency", done_c, 2);
      check("no_valid", (first_v < 0), 1);
    end else begin
      check("first_valid_cycle", first_v, n_eff + 2);
      check("done_after_last", done_c, last_acc + 1);
    end
    check("rule_held", ca_rule, ru);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_valid", m_valid, 0);
  endtask

  typedef struct {
    logic [31:0] s;
    logic [7:0]  ru;
    logic        l;
    logic        r;
    logic [4:0]  n;
    int          rmode;
    int          inject;
    int          exp_bytes;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cnt;
    logic [4:0] rn;
    reset = 1'b1; start = 1'b0; seed = 32'd0; rule_in = 8'd0; left_in = 1'b0;
    right_in = 1'b0; n_gens = 5'd0; m_ready = 1'b0;

    vecs[0] = '{32'hDEADBEEF, 8'd204, 1'b0, 1'b0, 5'd3,  0, 0, 12};
    vecs[1] = '{32'h00000001, 8'd0,   1'b0, 1'b0, 5'd2,  0, 0, 8};
    vecs[2] = '{32'hDEADBEEF, 8'd204, 1'b0, 1'b0, 5'd3,  1, 0, 12};
    vecs[3] = '{32'h12345678, 8'd90,  1'b0, 1'b0, 5'd0,  0, 0, 0};
    vecs[4] = '{32'h00010000, 8'd30,  1'b1, 1'b0, 5'd20, 0, 0, 64};
    vecs[5] = '{32'hDEADBEEF, 8'd204, 1'b0, 1'b0, 5'd3,  0, 1, 12};
    vecs[6] = '{32'h80000001, 8'd30,  1'b0, 1'b1, 5'd1,  1, 0, 4};
    vecs[7] = '{32'hC0FFEE11, 8'd110, 1'b1, 1'b1, 5'd16, 1, 0, 64};

    repeat (3) @(negedge clk);
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_set_state", ca_set_state, 0);
    check("rst_ca_state", ca_state, 0);
    check("rst_rule", {ca_rule, ca_left, ca_right}, 0);
    check("rst_data_last", {m_data, m_last}, 0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++)
      run_case(vecs[v].s, vecs[v].ru, vecs[v].l, vecs[v].r, vecs[v].n,
               vecs[v].rmode, vecs[v].inject, vecs[v].exp_bytes);

    // Reset in the middle of the drain, after five bytes have gone.
    @(negedge clk);
    seed = 32'hDEADBEEF; rule_in = 8'd204; left_in = 1'b0; right_in = 1'b0;
    n_gens = 5'd3; start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 5; c++) begin
      if (m_valid && m_ready) cnt++;
      @(negedge clk);
    end
    check("mid_reset_reached", cnt, 5);
    check("mid_reset_pending", m_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_valid", m_valid, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_done", done, 0);
    check("mid_reset_rule", ca_rule, 0);
    reset = 1'b0;
    run_case(32'hDEADBEEF, 8'd204, 1'b0, 1'b0, 5'd3, 0, 0, 12);

    for (int t = 0; t < 10; t++) begin
      rn = 5'($urandom_range(0, 20));
      run_case($urandom, 8'($urandom), 1'($urandom), 1'($urandom), rn,
               int'($urandom_range(0, 1)), 0, ((rn > 5'd16) ? 16 : int'(rn)) * 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
